// File: rtl/encoder_4to2_serial_if.sv
// Request/beat bus for encoder_4to2_serial: request vector in, one binary index out per beat.
// err_zero exists only when ENC_ZERO_FLAG_EN is defined.
interface encoder_4to2_serial_if #(
  parameter int unsigned N_IN = 4
);
  localparam int unsigned W_CODE = $clog2(N_IN);

  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_bits;
  logic              out_valid;
  logic              out_ready;
  logic [W_CODE-1:0] out_code;
  logic              out_last;
`ifdef ENC_ZERO_FLAG_EN
  logic              err_zero;
`endif

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_code, out_last
`ifdef ENC_ZERO_FLAG_EN
    , input err_zero
`endif
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_code, out_last
`ifdef ENC_ZERO_FLAG_EN
    , output err_zero
`endif
  );
endinterface

// File: rtl/encoder_4to2_serial.sv
// Serial priority encoder: emits the index of every set bit of an accepted vector, lowest first.
// Optional ENC_ZERO_FLAG_EN adds a one-cycle err_zero pulse when an all-zero vector is accepted.
module encoder_4to2_serial #(
  parameter int unsigned N_IN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  encoder_4to2_serial_if.slave  bus
);
  localparam int unsigned W_CODE = $clog2(N_IN);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   pending_q, pending_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [W_CODE-1:0] out_code_q, out_code_d;
  logic              out_last_q, out_last_d;
  logic              err_zero_d;

  function automatic logic [W_CODE-1:0] lowest_idx(input logic [N_IN-1:0] v);
    logic [W_CODE-1:0] idx;
    idx = '0;
    for (int i = int'(N_IN) - 1; i >= 0; i--) begin
      if (v[i]) idx = W_CODE'(i);
    end
    return idx;
  endfunction

  // Next state plus the output registers, which are computed from the next pending vector
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    err_zero_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_bits != '0) begin
            pending_d = bus.in_bits;
            state_d   = EMIT;
          end else begin
            err_zero_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          // clearing the lowest set bit retires the beat just handed off
          pending_d = pending_q & (pending_q - N_IN'(1));
          if (out_last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == EMIT);
    out_code_d  = lowest_idx(pending_d);
    out_last_d  = (pending_d != '0) && ((pending_d & (pending_d - N_IN'(1))) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef ENC_ZERO_FLAG_EN
  logic err_zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_zero_q <= 1'b0;
    else        err_zero_q <= err_zero_d;
  end

  assign bus.err_zero = err_zero_q;
`else
  logic unused_err_zero;
  assign unused_err_zero = err_zero_d;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_encoder_4to2_serial.sv
// Directed plus randomized bench for encoder_4to2_serial against a lowest-set-bit list model.
module tb_encoder_4to2_serial;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  encoder_4to2_serial_if #(.N_IN(4)) bus();

  encoder_4to2_serial #(.N_IN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_err(input string tag, input logic exp);
`ifdef ENC_ZERO_FLAG_EN
    check(tag, 32'(bus.err_zero), 32'(exp));
`else
    if (exp) check(tag, 32'd0, 32'd0);
`endif
  endtask

  // Accept one vector and drain it; the model is the ascending list of set-bit positions.
  task automatic run_vec(input logic [3:0] bits, input bit rand_stall, input int first_stall,
                         input bit noise);
    int exp_q[$];
    int st;
    for (int i = 0; i < 4; i++) if (((bits >> i) & 4'd1) != 4'd0) exp_q.push_back(i);

    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid  = 1'b1;
    bus.in_bits   = bits;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.in_bits  = 4'b0000;

    if (exp_q.size() == 0) begin
      check("zero_out_valid", 32'(bus.out_valid), 32'd0);
      check("zero_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef ENC_ZERO_FLAG_EN
      check("zero_err_pulse", 32'(bus.err_zero), 32'd1);
`endif
      step();
      check("zero_out_valid2", 32'(bus.out_valid), 32'd0);
      check_err("zero_err_clear", 1'b0);
      return;
    end

    if (noise) begin
      bus.in_valid = 1'b1;
      bus.in_bits  = 4'b0001;
    end
    for (int b = 0; b < exp_q.size(); b++) begin
      st = (b == 0) ? first_stall : 0;
      if (rand_stall) st = int'($urandom_range(0, 2));
      bus.out_ready = 1'b0;
      for (int s = 0; s < st; s++) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_code", 32'(bus.out_code), 32'(exp_q[b]));
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        step();
      end
      bus.out_ready = 1'b1;
      check("beat_valid", 32'(bus.out_valid), 32'd1);
      check("beat_code", 32'(bus.out_code), 32'(exp_q[b]));
      check("beat_last", 32'(bus.out_last), 32'(b == exp_q.size() - 1));
      check("beat_in_ready", 32'(bus.in_ready), 32'd0);
      check_err("beat_err", 1'b0);
      step();
      if (b == exp_q.size() - 1) begin
        bus.in_valid = 1'b0;
        bus.in_bits  = 4'b0000;
      end
    end
    bus.out_ready = 1'b0;
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bits   = 4'b0000;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_code", 32'(bus.out_code), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check_err("rst_err", 1'b0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_vec(4'b0100, 1'b0, 0, 1'b0);   // single bit
    run_vec(4'b1011, 1'b0, 0, 1'b0);   // three beats back to back
    run_vec(4'b1111, 1'b0, 5, 1'b0);   // stall on first beat
    run_vec(4'b0110, 1'b0, 0, 1'b1);   // input noise while emitting

    // Reset after the first beat of 4'b1001 must drop code 3.
    check("t5_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_bits   = 4'b1001;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_bits  = 4'b0000;
    check("t5_code0", 32'(bus.out_code), 32'd0);
    step();
    check("t5_code3_pending", 32'(bus.out_code), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(bus.out_valid), 32'd0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_no_valid", 32'(bus.out_valid), 32'd0);
      check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    end
    bus.out_ready = 1'b0;

    run_vec(4'b0000, 1'b0, 0, 1'b0);   // zero vector
    run_vec(4'b1000, 1'b0, 0, 1'b0);   // highest index alone
    run_vec(4'b0001, 1'b0, 3, 1'b0);

    for (int r = 0; r < 40; r++) begin
      run_vec(4'($urandom_range(0, 15)), 1'b1, 0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
